// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode bus for fetch_buffer: fetch push side, ID head side, occupancy.
interface fetch_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          start_i;
  logic          fetch_valid_i;
  logic [31:0]   pc_i;
  logic [31:0]   inst_i;
  logic          fetch_ready_o;
  logic          flush_i;
  logic          stall_i;
  logic          valid_o;
  logic [31:0]   pc_o;
  logic [31:0]   inst_o;
  logic [31:0]   pc_plus4_o;
  logic [CW-1:0] count_o;

  modport master (
    output start_i, fetch_valid_i, pc_i, inst_i, flush_i, stall_i,
    input  fetch_ready_o, valid_o, pc_o, inst_o, pc_plus4_o, count_o
  );

  modport slave (
    input  start_i, fetch_valid_i, pc_i, inst_i, flush_i, stall_i,
    output fetch_ready_o, valid_o, pc_o, inst_o, pc_plus4_o, count_o
  );
endinterface

// File: rtl/fetch_buffer.sv
// Circular instruction fetch buffer between IF and ID with flush/stall control.
// Define FETCH_BUF_BYPASS_EN to let an empty buffer forward the fetch straight to ID.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  fetch_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fb_entry_t;

  fb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  fb_entry_t in_e, head;
  logic      empty, ready, valid, push, pop, store, deq, consume_byp;

  assign in_e  = '{pc: bus.pc_i, inst: bus.inst_i};
  assign empty = (cnt_q == '0);
  assign ready = (cnt_q < CW'(DEPTH));

`ifdef FETCH_BUF_BYPASS_EN
  logic byp;
  assign byp = empty & bus.start_i & bus.fetch_valid_i & ~bus.flush_i;
`endif

  always_comb begin
    head  = '0;
    valid = 1'b0;
    if (!empty) begin
      valid = 1'b1;
      head  = mem_q[rd_q];
    end
`ifdef FETCH_BUF_BYPASS_EN
    else if (byp) begin
      valid = 1'b1;
      head  = in_e;
    end
`endif
  end

  assign push = bus.start_i & bus.fetch_valid_i & ready & ~bus.flush_i;
  assign pop  = bus.start_i & valid & ~bus.stall_i & ~bus.flush_i;

  // A bypassed fetch consumed by ID in the same cycle never touches storage.
`ifdef FETCH_BUF_BYPASS_EN
  assign consume_byp = byp & pop;
`else
  assign consume_byp = 1'b0;
`endif

  assign store = push & ~consume_byp;
  assign deq   = pop & ~consume_byp;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (bus.start_i && bus.flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (store) begin
        mem_d[wr_q] = in_e;
        wr_d        = wr_q + 1'b1;
      end
      if (deq) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(store) - CW'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.fetch_ready_o = ready;
  assign bus.valid_o       = valid;
  assign bus.pc_o          = head.pc;
  assign bus.inst_o        = head.inst;
  assign bus.pc_plus4_o    = head.pc + 32'd4;
  assign bus.count_o       = cnt_q;
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model plus directed literals.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_buffer_if #(.DEPTH(DEPTH)) bus ();
  fetch_buffer #(.DEPTH(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model view of the outputs for the current inputs.
  function automatic bit m_byp();
    return BYP && q.size() == 0 && bus.start_i && bus.fetch_valid_i && !bus.flush_i;
  endfunction

  task automatic compare_model();
    bit          v;
    logic [31:0] p, i;
    v = 1'b0; p = 32'h0; i = 32'h0;
    if (q.size() > 0) begin
      v = 1'b1; p = q[0].pc; i = q[0].inst;
    end else if (m_byp()) begin
      v = 1'b1; p = bus.pc_i; i = bus.inst_i;
    end
    chk("valid", bus.valid_o, v);
    chk("pc", bus.pc_o, p);
    chk("inst", bus.inst_o, i);
    chk("pc_plus4", bus.pc_plus4_o, p + 32'd4);
    chk("count", 32'(bus.count_o), q.size());
    chk("ready", bus.fetch_ready_o, q.size() < DEPTH);
  endtask

  task automatic drive(input bit r, input bit s, input bit fv, input bit fl, input bit st,
                       input logic [31:0] pc, input logic [31:0] inst);
    @(negedge clk);
    rst = r;
    bus.start_i = s; bus.fetch_valid_i = fv; bus.flush_i = fl; bus.stall_i = st;
    bus.pc_i = pc; bus.inst_i = inst;
    #1;
    compare_model();
  endtask

  task automatic tick();
    bit byp, valid, ready, pop, push;
    ent_t e;
    @(posedge clk);
    byp   = m_byp();
    valid = q.size() > 0 || byp;
    ready = q.size() < DEPTH;
    e.pc = bus.pc_i; e.inst = bus.inst_i;
    if (rst) q.delete();
    else if (bus.start_i) begin
      if (bus.flush_i) q.delete();
      else begin
        pop  = valid && !bus.stall_i;
        push = bus.fetch_valid_i && ready;
        if (!(byp && pop)) begin
          if (pop) void'(q.pop_front());
          if (push) q.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input bit st);
    drive(0, 1, 0, 0, st, 32'h0, 32'h0);
  endtask

  initial begin
    bus.start_i = 0; bus.fetch_valid_i = 0; bus.flush_i = 0; bus.stall_i = 0;
    bus.pc_i = 0; bus.inst_i = 0;
    repeat (2) @(posedge clk);

    // Reset state
    drive(1, 1, 0, 1, 0, 32'h0, 32'h0);
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_ready", bus.fetch_ready_o, 1);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_plus4", bus.pc_plus4_o, 32'h4);
    tick();

    // Three back-to-back pushes with decode consuming
    drive(0, 1, 1, 0, 0, 32'h0, 32'h13);
    chk("seq_c0_valid", bus.valid_o, BYP);
    tick();
    drive(0, 1, 1, 0, 0, 32'h4, 32'h113);
    chk("seq_c1_pc", bus.pc_o, BYP ? 32'h4 : 32'h0);
    chk("seq_c1_plus4", bus.pc_plus4_o, BYP ? 32'h8 : 32'h4);
    tick();
    drive(0, 1, 1, 0, 0, 32'h8, 32'h213);
    chk("seq_c2_pc", bus.pc_o, BYP ? 32'h8 : 32'h4);
    tick();
    idle(0);
    chk("seq_c3_valid", bus.valid_o, !BYP);
    if (!BYP) chk("seq_c3_plus4", bus.pc_plus4_o, 32'hC);
    tick();
    idle(0);
    chk("seq_c4_valid", bus.valid_o, 0);
    chk("seq_c4_inst", bus.inst_o, 32'h0);
    tick();

    // Fill under stall; fifth push refused
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, 0, 1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
      if (k == 4) chk("full_ready", bus.fetch_ready_o, 0);
      tick();
    end
    idle(1);
    chk("full_count", 32'(bus.count_o), 4);
    chk("full_pc", bus.pc_o, 32'h100);
    tick();

    // Full: pop with push offered -> push rejected
    drive(0, 1, 1, 0, 0, 32'h200, 32'hBB);
    chk("fullpp_ready", bus.fetch_ready_o, 0);
    tick();
    idle(1);
    chk("fullpp_count", 32'(bus.count_o), 3);
    chk("fullpp_ready_after", bus.fetch_ready_o, 1);
    chk("fullpp_pc", bus.pc_o, 32'h104);
    tick();

    // start_i low freezes everything, including flush
    drive(0, 0, 1, 1, 0, 32'h400, 32'hCC);
    tick();
    idle(1);
    chk("hold_count", 32'(bus.count_o), 3);
    chk("hold_pc", bus.pc_o, 32'h104);
    tick();

    // Flush with a concurrent push
    drive(0, 1, 1, 1, 0, 32'h300, 32'hDD);
    tick();
    idle(1);
    chk("flush_count", 32'(bus.count_o), 0);
    chk("flush_valid", bus.valid_o, 0);
    chk("flush_inst", bus.inst_o, 32'h0);
    tick();

    // PC wrap on pc_plus4
    drive(0, 1, 1, 0, 1, 32'hFFFF_FFFC, 32'hEE);
    tick();
    idle(1);
    chk("wrap_plus4", bus.pc_plus4_o, 32'h0);
    chk("wrap_count", 32'(bus.count_o), 1);
    tick();
    drive(0, 1, 0, 1, 1, 32'h0, 32'h0);
    tick();
    if (BYP) begin
      drive(0, 1, 1, 0, 0, 32'hFFFF_FFFC, 32'hEF);
      chk("byp_valid", bus.valid_o, 1);
      chk("byp_plus4", bus.pc_plus4_o, 32'h0);
      tick();
      idle(1);
      chk("byp_count", 32'(bus.count_o), 0);
      tick();
    end

    // Reset mid-operation drops stored entries and the in-flight push
    drive(0, 1, 1, 0, 1, 32'h500, 32'h1);
    tick();
    drive(1, 1, 1, 0, 1, 32'h504, 32'h2);
    tick();
    idle(1);
    chk("midrst_count", 32'(bus.count_o), 0);
    chk("midrst_valid", bus.valid_o, 0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 4,
            $urandom, $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
